// File: rtl/nibble_adder_arbiter.sv
// Two-requester wide adder that reuses a single 4-bit ripple slice.
// A grant captures the winner's operands. The add then runs one nibble per
// cycle, LSB nibble first, with the carry held in a register between nibbles.
// The result is published together with a one-cycle done pulse.

// One-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_adder_arbiter #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  output logic [1:0]             gnt,
  output logic                   busy,
  output logic [1:0]             done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic                      carry;
  logic                      id;
  logic                      lst;
  logic [NIBBLES-1:0][3:0]   op_a, op_b, wsum, wsum_nxt;
  logic [3:0]                sa, sb, ss;
  logic [4:0]                c;
  logic                      sel_id;
  logic                      sel_vld;
  logic                      last_nib;

  // Operand nibble currently being added.
  assign sa = op_a[idx];
  assign sb = op_b[idx];

  // The shared 4-bit ripple slice. Its carry-in comes from the carry register.
  assign c[0] = carry;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    fulladder u_fa (.a(sa[g]), .b(sb[g]), .ci(c[g]), .s(ss[g]), .co(c[g+1]));
  end

  // Round-robin pick. Under contention the requester not served last wins.
  always_comb begin
    sel_id = req[1];
    if (req == 2'b11) sel_id = ~lst;
  end

  assign sel_vld  = (state == IDLE) && (|req);
  assign gnt      = sel_vld ? (sel_id ? 2'b10 : 2'b01) : 2'b00;
  assign done     = (state == DONE) ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state != IDLE) || sel_vld;
  assign last_nib = (idx == IW'(NIBBLES - 1));

  // Working sum with the current slice result merged into nibble [idx].
  always_comb begin
    wsum_nxt      = wsum;
    wsum_nxt[idx] = ss;
  end

  // Control FSM plus the operand, working-sum and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      id    <= 1'b0;
      lst   <= 1'b1;
      op_a  <= '0;
      op_b  <= '0;
      wsum  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_vld) begin
          op_a  <= sel_id ? a1 : a0;
          op_b  <= sel_id ? b1 : b0;
          id    <= sel_id;
          lst   <= sel_id;
          idx   <= '0;
          carry <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          wsum  <= wsum_nxt;
          carry <= c[4];
          idx   <= idx + 1'b1;
          if (last_nib) begin
            sum   <= wsum_nxt;
            cout  <= c[4];
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Directed bench for nibble_adder_arbiter with NIBBLES=4 (16-bit operands).
module tb_nibble_adder_arbiter;
  localparam int NIB = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic        busy;
  logic [1:0]  done;
  logic [15:0] sum;
  logic        cout;

  int          n_pass;
  int          n_tot;
  logic [15:0] last_sum;
  logic        last_cout;

  nibble_adder_arbiter #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Follows a granted operation to its done pulse, checking latency and result.
  task automatic wait_done(input logic [1:0] eg, input logic [15:0] es, input logic ec,
                           input bit drop, input bit chg);
    int lat;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1 && drop) req = 2'b00;
      if (k == 1 && chg)  a0  = 16'hFFFF;
      @(negedge clk);
      if (done !== 2'b00) begin
        lat = k;
        break;
      end
      chk("run_hold_sum", sum, last_sum);
      chk("run_hold_cout", cout, last_cout);
      chk("run_busy", busy, 1);
      chk("run_gnt", gnt, 0);
    end
    chk("latency", lat, NIB + 1);
    chk("done", done, eg);
    chk("done_busy", busy, 1);
    chk("done_gnt", gnt, 0);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    last_sum  = es;
    last_cout = ec;
  endtask

  task automatic op(input logic [1:0] r, input logic [15:0] va0, vb0, va1, vb1,
                    input logic [1:0] eg, input logic [15:0] es, input logic ec,
                    input bit drop, input bit chg);
    @(posedge clk); #1;
    req = r; a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
    @(negedge clk);
    chk("gnt", gnt, eg);
    chk("grant_busy", busy, 1);
    chk("grant_done", done, 0);
    wait_done(eg, es, ec, drop, chg);
    req = 2'b00;
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    chk("rst_done_hold", done, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_sum  = '0;
    last_cout = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    rst_n = 1'b0; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_sum = '0; last_cout = 1'b0;

    //          req    a0        b0        a1        b1        gnt    sum       cout
    vecs[0] = '{2'b01, 16'h1234, 16'h0FCD, 16'h1111, 16'h1111, 2'b01, 16'h2201, 1'b0};
    vecs[1] = '{2'b10, 16'h2222, 16'h3333, 16'hFFFF, 16'h0001, 2'b10, 16'h0000, 1'b1};
    vecs[2] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 2'b01, 16'hFFFE, 1'b1};
    vecs[3] = '{2'b10, 16'h4444, 16'h4444, 16'h0F0F, 16'h00F1, 2'b10, 16'h1000, 1'b0};
    vecs[4] = '{2'b01, 16'h8000, 16'h7FFF, 16'h1357, 16'h2468, 2'b01, 16'hFFFF, 1'b0};
    vecs[5] = '{2'b10, 16'h0101, 16'h0202, 16'hA5A5, 16'h5A5B, 2'b10, 16'h0000, 1'b1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++)
      op(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
         vecs[i].gnt, vecs[i].sum, vecs[i].cout, 1'b0, 1'b0);

    // Operand change after the grant must not affect the result.
    op(2'b01, 16'h00FF, 16'h0001, 16'h0000, 16'h0000, 2'b01, 16'h0100, 1'b0, 1'b0, 1'b1);

    // Dropping req mid-operation still completes the add.
    op(2'b10, 16'h0000, 16'h0000, 16'h1234, 16'h1111, 2'b10, 16'h2345, 1'b0, 1'b1, 1'b0);

    // Contention after reset: 01 first, then alternate while both are held.
    do_reset();
    @(posedge clk); #1;
    req = 2'b11; a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h8000; b1 = 16'h8000;
    @(negedge clk);
    chk("rr_gnt0", gnt, 2'b01);
    wait_done(2'b01, 16'h0003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rr_gnt1", gnt, 2'b10);
    wait_done(2'b10, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rr_gnt2", gnt, 2'b01);
    wait_done(2'b01, 16'h0003, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rr_idle_gnt", gnt, 0);
    chk("rr_idle_busy", busy, 0);

    // Reset two cycles into RUN aborts the operation without a done pulse.
    op(2'b01, 16'h1000, 16'h0234, 16'h0000, 16'h0000, 2'b01, 16'h1234, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 2'b01; a0 = 16'h0001; b0 = 16'h0001;
    @(negedge clk);
    chk("abort_gnt", gnt, 2'b01);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_done", done, 0);
    chk("abort_pre_sum", sum, 16'h1234);
    do_reset();
    op(2'b01, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
